// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM states, legal prescale values, parity types.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   PRESCALE_8         = 8;
    localparam int   PRESCALE_16        = 16;
    localparam int   PRESCALE_32        = 32;
    localparam logic PAR_EVEN           = 1'b0;
    localparam logic PAR_ODD            = 1'b1;
    localparam int   DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line and frame configuration in, received byte and status pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept DATA_VALID / PAR_ERR / STP_ERR pulses when they occur.
// master: line/config driver and result consumer. slave: the receiver.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: edge/bit counters plus 3-sample majority vote.
// Latency: majority decision registered, valid at edge_cnt = P/2+2 of each bit period.
// Backpressure: none; counters free-run while clr is low.
// Ports: clr holds counters at 0; rx is the registered line; prescale is the latched P;
//        sampled_bit/sample_valid give the voted bit; bit_done marks edge_cnt = P-1; bit_cnt counts wraps.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  bit_done,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  sample_valid_q, sample_valid_d;

    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;
    logic                  edge_wrap;

    always_comb begin
        half      = prescale >> 1;
        last      = prescale - PRESCALE_W'(1);
        edge_wrap = (edge_cnt_q == last);

        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        s0_d           = s0_q;
        s1_d           = s1_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;

        if (clr) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (edge_wrap) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        end else begin
            edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
        end

        if (edge_cnt_q == half - PRESCALE_W'(1)) s0_d = rx;
        if (edge_cnt_q == half)                  s1_d = rx;

        // Third sample is taken live; the vote lands in a flop so it is seen at P/2+2.
        if (!clr && (edge_cnt_q == half + PRESCALE_W'(1))) begin
            sample_valid_d = 1'b1;
            sampled_bit_d  = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            s0_q           <= 1'b1;
            s1_q           <= 1'b1;
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
        end else begin
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign bit_done     = edge_wrap;
    assign bit_cnt      = bit_cnt_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deframes start, LSB-first data, optional parity and stop bits from an oversampled line.
// Latency: DATA_VALID/P_DATA appear (1+DATA_WIDTH+PAR_EN+1)*P+2 cycles after the start bit reaches RX_IN.
// Backpressure: none; results and error flags are single-cycle pulses the consumer must take.
// Ports: CLK oversampling clock, RST async active-low reset, bus (slave) carries line, config and results.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    uart_state_e state_q, state_d;

    logic                  rx_q, rx_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PRESCALE_W-1:0] prescale_l_q, prescale_l_d;
    logic                  par_en_l_q, par_en_l_d;
    logic                  par_typ_l_q, par_typ_l_d;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  bad_q, bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  bit_done;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  cnt_clr;
    logic                  par_expect;

    // Every state change happens on a wrap or a glitch abort, so restarting the
    // counters on any change (and while idle) keeps edge_cnt aligned to the bit.
    assign cnt_clr = (state_q == ST_IDLE) || (state_d != state_q);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_sampler (
        .clk          (CLK),
        .rst_n        (RST),
        .clr          (cnt_clr),
        .rx           (rx_q),
        .prescale     (prescale_l_q),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .bit_done     (bit_done),
        .bit_cnt      (bit_cnt)
    );

    always_comb begin
        rx_d       = bus.RX_IN;
        prescale_d = bus.PRESCALE;
        par_en_d   = bus.PAR_EN;
        par_typ_d  = bus.PAR_TYP;

        par_expect = (par_typ_l_q == PAR_ODD) ? ~^shift_q : ^shift_q;

        state_d      = state_q;
        prescale_l_d = prescale_l_q;
        par_en_l_d   = par_en_l_q;
        par_typ_l_d  = par_typ_l_q;
        shift_d      = shift_q;
        bad_d        = bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_q) state_d = ST_START;
            end
            ST_START: begin
                if (sample_valid && sampled_bit) state_d = ST_IDLE;
                else if (bit_done)               state_d = ST_DATA;
            end
            ST_DATA: begin
                // Shift in at the MSB; after DATA_WIDTH bits the first bit sits at the LSB.
                if (sample_valid) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                if (bit_done && (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))) begin
                    state_d = par_en_l_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (sample_valid && (sampled_bit != par_expect)) begin
                    par_err_d = 1'b1;
                    bad_d     = 1'b1;
                end
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (sample_valid && !sampled_bit) begin
                    stp_err_d = 1'b1;
                    bad_d     = 1'b1;
                end
                if (bit_done) begin
                    if (!bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    // The wrap cycle doubles as the first idle look at the line, so a
                    // start bit directly after the stop bit keeps exact frame spacing.
                    state_d = rx_q ? ST_IDLE : ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_START) && (state_q != ST_START)) begin
            prescale_l_d = prescale_q;
            par_en_l_d   = par_en_q;
            par_typ_l_d  = par_typ_q;
            bad_d        = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            rx_q         <= 1'b1;
            prescale_q   <= PRESCALE_W'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            prescale_l_q <= PRESCALE_W'(PRESCALE_8);
            par_en_l_q   <= 1'b0;
            par_typ_l_q  <= PAR_EVEN;
            shift_q      <= '0;
            bad_q        <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_q         <= rx_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            prescale_l_q <= prescale_l_d;
            par_en_l_q   <= par_en_l_d;
            par_typ_l_q  <= par_typ_l_d;
            shift_q      <= shift_d;
            bad_q        <= bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver.
- Counterpart of the UART TX path, including its parity generator: even parity bit = XOR of data bits, odd parity bit = XNOR of data bits.
- Oversamples RX_IN on CLK and deframes start, data (LSB first), optional parity and stop bits.
- Presents P_DATA with a one-cycle DATA_VALID pulse, plus parity and stop error flags, to the system-side consumer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the PRESCALE port.

Ports:
- CLK  in  1  oversampling clock; one sample per rising edge.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line; idles high.
- PRESCALE  in  PRESCALE_W  CLK cycles per bit; legal values 8, 16, 32.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd.
- P_DATA  out  DATA_WIDTH  last correctly received byte.
- DATA_VALID  out  1  one-cycle pulse; P_DATA is updated in the same cycle.
- PAR_ERR  out  1  one-cycle pulse on parity mismatch.
- STP_ERR  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is asynchronous and active-low.
- Reset: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0; FSM=IDLE; all counters 0.
- Reset asserted mid-frame aborts the frame immediately; no pulses are issued.
- Inputs are registered once before use; RX_IN latency is absorbed in the counters.
- PAR_EN, PAR_TYP and PRESCALE are latched on IDLE->START. Changes mid-frame have no effect.
- Illegal PRESCALE values are undefined and are not driven by the bench.
- edge_cnt runs 0..PRESCALE-1 within each bit period, then wraps to 0 and increments bit_cnt.
- Sample point: majority of the 3 samples at edge_cnt = P/2-1, P/2, P/2+1 (P = latched prescale). The decision is registered at edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: registered RX_IN==0 -> START, with edge_cnt=0.
  - START: if the sampled bit is 1, it is a glitch -> IDLE at the decision cycle with no error pulse. Otherwise -> DATA at edge_cnt wrap.
  - DATA: shift the sampled bit into shift register bit position bit_cnt (LSB first). After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: expected = ^shift (even) or ~^shift (odd). On mismatch, PAR_ERR pulses at the decision cycle. The frame is marked bad. -> STOP at wrap.
  - STOP: sampled 0 -> STP_ERR pulses at the decision cycle.
    - At edge_cnt = P-1: if no error in the frame, P_DATA <= shift and DATA_VALID pulses in that cycle.
    - Go to IDLE in the same cycle.
- Bad frames never update P_DATA and never pulse DATA_VALID.
- PAR_ERR and STP_ERR may both pulse in one frame, on different cycles.
- Back-to-back frames: a start bit immediately following the stop bit is detected from IDLE on the next cycle. No frame is lost at P>=8.
- RX_IN held low indefinitely (break): the START check passes, data bits are 0, the stop bit fails and STP_ERR fires. The FSM then restarts from IDLE while the line stays low; each restart repeats the same frame-with-STP_ERR sequence.
- Frame length in CLK cycles: (1 + DATA_WIDTH + PAR_EN + 1) * P.
  - Example: P=8, 8 data bits, parity enabled -> 88 cycles from start-edge detection to DATA_VALID.

Decomposition:
- Package uart_pkg: FSM state enum; constants PRESCALE_8/16/32, PAR_EVEN=0, PAR_ODD=1, DEFAULT_DATA_WIDTH=8. Shared with the TX side.
- Sub-module uart_rx_sampler: edge_cnt/bit_cnt counters and 3-sample majority vote. Outputs: sampled_bit, sample_valid, bit_done.
- The top level holds the FSM, the shift register and the parity/stop checks.

Test Plan:
- P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0, stop=1 -> DATA_VALID pulses once, P_DATA=0xA5, no errors, 88 cycles after start detect.
- P=16, PAR_EN=1, PAR_TYP=1, frame 0x3C with parity bit 0 (wrong; odd expects 1) -> PAR_ERR pulses once, no DATA_VALID, P_DATA keeps its previous value.
- P=32, PAR_EN=0, frame 0x81 with stop bit 0 -> STP_ERR pulses once, no DATA_VALID; the following frame 0x55 is received correctly.
- P=8, 3-cycle low glitch on RX_IN in IDLE -> FSM returns to IDLE, no pulses; a subsequent valid 0x0F frame gives P_DATA=0x0F.
- Two back-to-back frames 0x12, 0x34 at P=16 with no idle gap -> two DATA_VALID pulses, 160 cycles apart, with the correct bytes.
- RST driven low mid-DATA of 0xFF, then released, then a valid frame 0x77 -> all outputs 0 during reset, no spurious pulse, P_DATA=0x77 afterwards.
